// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 2;

endpackage

// File: rtl/imem_loader_if.sv
// Word-stream handshake plus byte write port of the instruction memory.
// slave: the loader's view; master: the program source / memory side.
interface imem_loader_if #(
    parameter int unsigned XLEN = 32
);
    logic            word_valid;
    logic [31:0]     word_data;
    logic            word_last;
    logic            word_ready;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [7:0]      mem_wdata;

    modport master (
        output word_valid, word_data, word_last,
        input  word_ready,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  word_valid, word_data, word_last,
        output word_ready,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_byte_serializer.sv
// Splits a 32-bit word into four little-endian bytes, one per cycle.
// byte_data_o holds its last value once the sequence ends.
module imem_byte_serializer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [31:0]       word_i,
    output logic              byte_valid_o,
    output logic [LANE_W-1:0] byte_lane_o,
    output logic [7:0]        byte_data_o,
    output logic              byte_done_o
);
    logic [31:0]       word_q;
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_nxt;
    logic              valid_q;
    logic [7:0]        data_q;
    logic              last_lane;

    assign lane_nxt  = lane_q + LANE_W'(1);
    assign last_lane = valid_q && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    // Capture the word on load, then step the lane and pre-select the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            word_q  <= word_i;
            lane_q  <= '0;
            valid_q <= 1'b1;
            data_q  <= word_i[7:0];
        end else if (valid_q) begin
            if (last_lane) begin
                valid_q <= 1'b0;
            end else begin
                lane_q <= lane_nxt;
                data_q <= word_q[{lane_nxt, 3'b000} +: 8];
            end
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_lane_o  = lane_q;
    assign byte_data_o  = data_q;
    assign byte_done_o  = last_lane;

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory
// write port (little-endian) and holds the core in reset until a load ends.
// Optional: define IMEM_LOADER_CHECKSUM_EN to accumulate a sum of accepted
// words on the checksum port; otherwise checksum reads as zero.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int unsigned     MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold,
    output logic [15:0]   word_count,
    output logic [31:0]   checksum
);
    loader_state_t     state_q;
    logic [XLEN-1:0]   ptr_q;
    logic [XLEN-1:0]   addr_q;
    logic [15:0]       count_q;
    logic [15:0]       count_inc;
    logic              last_q;
    logic              word_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cpu_hold_q;

    logic              accept;
    logic              start_ok;
    logic              ser_done;
    logic [LANE_W-1:0] ser_lane;

    assign accept    = (state_q == LOAD) && bus.word_valid;
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign count_inc = count_q + 16'd1;

    imem_byte_serializer u_serializer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept),
        .word_i       (bus.word_data),
        .byte_valid_o (bus.mem_we),
        .byte_lane_o  (ser_lane),
        .byte_data_o  (bus.mem_wdata),
        .byte_done_o  (ser_done)
    );

    // Load sequencer: state, address pointer, word count and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            last_q       <= 1'b0;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q      <= LOAD;
                        ptr_q        <= BASE_ADDR;
                        count_q      <= '0;
                        err_q        <= 1'b0;
                        word_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        cpu_hold_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        state_q      <= WRITE;
                        last_q       <= bus.word_last;
                        addr_q       <= ptr_q;
                        word_ready_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (ser_done) begin
                        ptr_q   <= ptr_q + XLEN'(BYTES_PER_WORD);
                        count_q <= count_inc;
                        // A flagged last word wins over hitting the word limit.
                        if (last_q || (count_inc == 16'(MAX_WORDS))) begin
                            state_q    <= DONE;
                            err_q      <= !last_q;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q      <= LOAD;
                            word_ready_q <= 1'b1;
                        end
                    end else begin
                        addr_q <= ptr_q + XLEN'(ser_lane) + XLEN'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Running modulo-2^32 sum of accepted words, cleared when a load starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q + bus.word_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign bus.word_ready = word_ready_q;
    assign bus.mem_addr   = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cpu_hold       = cpu_hold_q;
    assign word_count     = count_q;

endmodule
